// File: rtl/video_timing_pkg.sv
// Shared constants and helpers for the video timing generator.
// Holds the default raster timing, the sync-offset input widths and the
// clamp used by both axes to place the sync pulse inside the blanking area.
package video_timing_pkg;

  localparam int HTOTAL_DEF    = 456;
  localparam int HACTIVE_DEF   = 336;
  localparam int HSYNC_POS_DEF = 360;
  localparam int HSYNC_W_DEF   = 24;
  localparam int VTOTAL_DEF    = 262;
  localparam int VACTIVE_DEF   = 240;
  localparam int VSYNC_POS_DEF = 240;
  localparam int VSYNC_W_DEF   = 3;
  localparam int HLEAD_DEF     = 1;
  localparam int RGB_W_DEF     = 8;

  localparam int HOFFS_W = 5;
  localparam int VOFFS_W = 3;
  localparam int CNT_W   = 9;

  // Wide enough that position + scaled offset never wraps for any 9-bit raster.
  localparam int CLAMP_W = 12;
  typedef logic signed [CLAMP_W-1:0] clamp_t;

  function automatic clamp_t clamp_start(input clamp_t v, input clamp_t lo, input clamp_t hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/video_timing_if.sv
// Pixel-side bundle of the video timing generator.
// The master modport is the core feeding pixels and offsets; the slave is
// the generator. CSYN exists only when VIDEO_TIMING_CSYNC_EN is defined.
interface video_timing_if
  import video_timing_pkg::*;
#(
  parameter int RGB_W = RGB_W_DEF
);
  logic               CE;
  logic [HOFFS_W-1:0] HOFFS;
  logic [VOFFS_W-1:0] VOFFS;
  logic [RGB_W-1:0]   iRGB;
  logic [CNT_W-1:0]   HPOS;
  logic [CNT_W-1:0]   VPOS;
  logic [RGB_W-1:0]   oRGB;
  logic               HBLK;
  logic               VBLK;
  logic               HSYN;
  logic               VSYN;
  logic               LINE;
  logic               FRAME;
`ifdef VIDEO_TIMING_CSYNC_EN
  logic               CSYN;
`endif

  modport master (
    output CE, HOFFS, VOFFS, iRGB,
    input  HPOS, VPOS, oRGB, HBLK, VBLK, HSYN, VSYN, LINE, FRAME
`ifdef VIDEO_TIMING_CSYNC_EN
    , input CSYN
`endif
  );

  modport slave (
    input  CE, HOFFS, VOFFS, iRGB,
    output HPOS, VPOS, oRGB, HBLK, VBLK, HSYN, VSYN, LINE, FRAME
`ifdef VIDEO_TIMING_CSYNC_EN
    , output CSYN
`endif
  );

endinterface

// File: rtl/video_timing_gen_axis.sv
// One raster axis (horizontal or vertical): position counter with wrap,
// frame-latched sync offset, and combinational blank/sync decode of the
// current count. Decodes are registered by the top on CE cycles.
module vt_axis
  import video_timing_pkg::*;
#(
  parameter int TOTAL    = HTOTAL_DEF,
  parameter int ACTIVE   = HACTIVE_DEF,
  parameter int SYNC_POS = HSYNC_POS_DEF,
  parameter int SYNC_W   = HSYNC_W_DEF,
  parameter int OFFS_W   = HOFFS_W,
  parameter int STEP     = 2
) (
  input  logic              clk_sys,
  input  logic              RESET_N,
  input  logic              adv_i,
  input  logic              load_i,
  input  logic [OFFS_W-1:0] offs_i,
  output logic [CNT_W-1:0]  cnt_o,
  output logic              wrap_o,
  output logic              blk_d_o,
  output logic              syn_d_o
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [OFFS_W-1:0] offs_q;
  clamp_t            offs_ext, start, cnt_ext;

  assign cnt_d   = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
  assign wrap_o  = adv_i && (cnt_q == LAST);
  assign cnt_o   = cnt_q;

  // Counter advances on adv_i; offset only changes at the frame boundary.
  always_ff @(posedge clk_sys) begin
    if (!RESET_N) begin
      cnt_q  <= '0;
      offs_q <= '0;
    end else begin
      if (adv_i)  cnt_q  <= cnt_d;
      if (load_i) offs_q <= offs_i;
    end
  end

  // Blank and sync decode of the current count.
  always_comb begin
    offs_ext = {{(CLAMP_W-OFFS_W){offs_q[OFFS_W-1]}}, offs_q};
    start    = clamp_start(clamp_t'(SYNC_POS) + clamp_t'(STEP) * offs_ext,
                           clamp_t'(ACTIVE), clamp_t'(TOTAL - SYNC_W));
    cnt_ext  = clamp_t'({1'b0, cnt_q});
    blk_d_o  = (cnt_q >= CNT_W'(ACTIVE));
    syn_d_o  = !((cnt_ext >= start) && (cnt_ext < start + clamp_t'(SYNC_W)));
  end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: H/V counters, blanking, offsettable sync pulses,
// blanked pixel output and line/frame strobes, all advancing on CE.
// Optional composite sync output enabled by defining VIDEO_TIMING_CSYNC_EN.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int HTOTAL    = HTOTAL_DEF,
  parameter int HACTIVE   = HACTIVE_DEF,
  parameter int HSYNC_POS = HSYNC_POS_DEF,
  parameter int HSYNC_W   = HSYNC_W_DEF,
  parameter int VTOTAL    = VTOTAL_DEF,
  parameter int VACTIVE   = VACTIVE_DEF,
  parameter int VSYNC_POS = VSYNC_POS_DEF,
  parameter int VSYNC_W   = VSYNC_W_DEF,
  parameter int HLEAD     = HLEAD_DEF,
  parameter int RGB_W     = RGB_W_DEF
) (
  input  logic           clk_sys,
  input  logic           RESET_N,
  video_timing_if.slave  vid
);
  if (HACTIVE >= HTOTAL || VACTIVE >= VTOTAL || HSYNC_W > HTOTAL - HACTIVE ||
      VSYNC_W > VTOTAL - VACTIVE || HTOTAL > 512 || VTOTAL > 512) begin : g_bad_cfg
    $error("video_timing_gen: illegal timing parameters");
  end

  localparam logic [9:0] HT10 = 10'(HTOTAL);

  logic [CNT_W-1:0] hcnt, vcnt;
  logic             h_wrap, v_wrap;
  logic             hblk_d, vblk_d, hsyn_d, vsyn_d;
  logic             hblk_q, vblk_q, hsyn_q, vsyn_q, line_q, frame_q;
  logic [RGB_W-1:0] rgb_q;
  logic [9:0]       hsum;

  // The V axis steps on the H wrap; both offsets reload on the frame wrap.
  vt_axis #(
    .TOTAL(HTOTAL), .ACTIVE(HACTIVE), .SYNC_POS(HSYNC_POS), .SYNC_W(HSYNC_W),
    .OFFS_W(HOFFS_W), .STEP(2)
  ) u_h (
    .clk_sys(clk_sys), .RESET_N(RESET_N), .adv_i(vid.CE), .load_i(v_wrap),
    .offs_i(vid.HOFFS), .cnt_o(hcnt), .wrap_o(h_wrap), .blk_d_o(hblk_d), .syn_d_o(hsyn_d)
  );

  vt_axis #(
    .TOTAL(VTOTAL), .ACTIVE(VACTIVE), .SYNC_POS(VSYNC_POS), .SYNC_W(VSYNC_W),
    .OFFS_W(VOFFS_W), .STEP(1)
  ) u_v (
    .clk_sys(clk_sys), .RESET_N(RESET_N), .adv_i(h_wrap), .load_i(v_wrap),
    .offs_i(vid.VOFFS), .cnt_o(vcnt), .wrap_o(v_wrap), .blk_d_o(vblk_d), .syn_d_o(vsyn_d)
  );

  assign hsum     = {1'b0, hcnt} + 10'(HLEAD);
  assign vid.HPOS = (hsum >= HT10) ? 9'(hsum - HT10) : hsum[8:0];
  assign vid.VPOS = vcnt;

  // Output stage: decodes captured on CE, strobes live for a single clock.
  always_ff @(posedge clk_sys) begin
    if (!RESET_N) begin
      hblk_q  <= 1'b1;
      vblk_q  <= 1'b1;
      hsyn_q  <= 1'b1;
      vsyn_q  <= 1'b1;
      rgb_q   <= '0;
      line_q  <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      line_q  <= h_wrap;
      frame_q <= v_wrap;
      if (vid.CE) begin
        hblk_q <= hblk_d;
        vblk_q <= vblk_d;
        hsyn_q <= hsyn_d;
        vsyn_q <= vsyn_d;
        rgb_q  <= (hblk_d || vblk_d) ? '0 : vid.iRGB;
      end
    end
  end

  assign vid.HBLK  = hblk_q;
  assign vid.VBLK  = vblk_q;
  assign vid.HSYN  = hsyn_q;
  assign vid.VSYN  = vsyn_q;
  assign vid.oRGB  = rgb_q;
  assign vid.LINE  = line_q;
  assign vid.FRAME = frame_q;

`ifdef VIDEO_TIMING_CSYNC_EN
  logic csyn_q;

  // Composite sync tracks HSYN/VSYN with the same one-CE latency.
  always_ff @(posedge clk_sys) begin
    if (!RESET_N)    csyn_q <= 1'b1;
    else if (vid.CE) csyn_q <= hsyn_d & vsyn_d;
  end

  assign vid.CSYN = csyn_q;
`endif

endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 SHALL have these parameters (name, default, meaning):
- HTOTAL, 456, pixels per line
- HACTIVE, 336, visible pixels per line
- HSYNC_POS, 360, nominal HSYN start pixel
- HSYNC_W, 24, HSYN width in pixels
- VTOTAL, 262, lines per frame
- VACTIVE, 240, visible lines
- VSYNC_POS, 240, nominal VSYN start line
- VSYNC_W, 3, VSYN width in lines
- HLEAD, 1, pixels by which HPOS leads the displayed pixel
- RGB_W, 8, pixel bus width
REQ-002 SHALL have these ports (name, direction, width, meaning):
- clk_sys, in, 1, sole clock
- RESET_N, in, 1, synchronous active-low reset
- CE, in, 1, pixel enable
- HOFFS, in, 5, signed horizontal sync offset, 2-pixel steps
- VOFFS, in, 3, signed vertical sync offset, 1-line steps
- iRGB, in, RGB_W, pixel from core
- HPOS, out, 9, fetch column
- VPOS, out, 9, current line
- oRGB, out, RGB_W, blanked pixel
- HBLK, out, 1, horizontal blank
- VBLK, out, 1, vertical blank
- HSYN, out, 1, horizontal sync, active-low
- VSYN, out, 1, vertical sync, active-low
- LINE, out, 1, line-start strobe
- FRAME, out, 1, frame-start strobe

Function
REQ-003 hcnt SHALL advance only on clk_sys edges with CE=1, counting 0..HTOTAL-1, then wrapping to 0 and advancing vcnt.
REQ-004 vcnt SHALL count 0..VTOTAL-1, then wrap to 0.
REQ-005 With CE=0, all state and outputs SHALL hold, except that LINE and FRAME SHALL be 0.
REQ-006 HPOS SHALL equal (hcnt+HLEAD) mod HTOTAL, combinationally.
REQ-007 VPOS SHALL equal vcnt, combinationally.
REQ-008 HBLK, VBLK, HSYN, VSYN and oRGB SHALL be registered on CE cycles from the pre-edge counter values: one CE of latency.
REQ-009 Blanking SHALL be decoded as HBLK=(hcnt>=HACTIVE) and VBLK=(vcnt>=VACTIVE).
REQ-010 oRGB SHALL be 0 when either blank term is set; otherwise it SHALL be iRGB.
REQ-011 The HSYN start hs_b SHALL be HSYNC_POS+2*HOFFS_lat, clamped to [HACTIVE, HTOTAL-HSYNC_W]; HSYN SHALL be 0 for hcnt in [hs_b, hs_b+HSYNC_W-1].
REQ-012 The VSYN start vs_b SHALL be VSYNC_POS+VOFFS_lat, clamped to [VACTIVE, VTOTAL-VSYNC_W]; VSYN SHALL be 0 for vcnt in [vs_b, vs_b+VSYNC_W-1].
REQ-013 HOFFS_lat and VOFFS_lat SHALL load from HOFFS and VOFFS only on the CE cycle where hcnt=HTOTAL-1 and vcnt=VTOTAL-1; mid-frame changes SHALL never alter the current frame.
REQ-014 LINE SHALL pulse for one clk_sys cycle on each CE edge where hcnt wraps to 0.
REQ-015 FRAME SHALL pulse for one clk_sys cycle on each CE edge where both counters wrap to 0.
REQ-016 Clamp arithmetic SHALL use at least 11-bit signed intermediates, so that no wrap-around occurs.
REQ-017 Elaboration SHALL fail if HACTIVE>=HTOTAL, VACTIVE>=VTOTAL, HSYNC_W>HTOTAL-HACTIVE, VSYNC_W>VTOTAL-VACTIVE, or HTOTAL>512.

Reset
REQ-018 While RESET_N=0 at an edge, regardless of CE, the block SHALL set:
- hcnt=vcnt=0
- HOFFS_lat=VOFFS_lat=0
- HBLK=VBLK=1
- HSYN=VSYN=1
- oRGB=0
- LINE=FRAME=0
REQ-019 Reset asserted mid-line SHALL take effect at that edge. The first CE edge after release SHALL present outputs for (0,0), with HBLK=0 and VBLK=0.

Configuration
REQ-020 With VIDEO_TIMING_CSYNC_EN defined, the block SHALL add output CSYN (1 bit, active-low), registered as HSYN AND VSYN with identical latency and a reset value of 1.
REQ-021 Without VIDEO_TIMING_CSYNC_EN, the CSYN port and its logic SHALL be absent.

Structure
REQ-022 Package video_timing_pkg SHALL hold:
- the default timing constants
- the offset width constants
- a clamp function shared by the H and V axes
REQ-023 The module SHALL instantiate sub-module vt_axis twice (H and V). Each instance SHALL contain counter, wrap, blank decode and sync decode; the H instance SHALL drive the V instance's advance enable.

Verification
REQ-024 Defaults, CE=1 continuous, HOFFS=0 -> LINE period 456 cycles; HSYN low for 24 CEs starting one CE after hcnt=360; HBLK high from one CE after hcnt=336.
REQ-025 HOFFS=+5 -> HSYN low during hcnt 370..393. HOFFS=-16 -> start clamps to 336; HSYN low during 336..359.
REQ-026 VOFFS changed from 0 to +3 at vcnt=100 -> current frame VSYN on lines 240..242; next frame VSYN on lines 243..245; FRAME period 456*262 CEs.
REQ-027 CE pattern 1-0-0 (one in three) -> counters and outputs advance only on CE cycles; LINE and FRAME stay 1 cycle wide; LINE period 1368 cycles.
REQ-028 RESET_N low for 1 cycle at hcnt=200, vcnt=50 -> next cycle hcnt=0, vcnt=0, HBLK=VBLK=1, HSYN=VSYN=1, oRGB=0. The first CE after release gives HBLK=VBLK=0 and oRGB=iRGB.
REQ-029 With VIDEO_TIMING_CSYNC_EN defined -> CSYN is 0 exactly when HSYN=0 or VSYN=0, on every cycle across a full frame.
